vga_timing_gen: RTL and testbench

// - Drives the pattern generators: produces the row/column coordinates they decode and samples their

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_timing_gen_if.sv | 22 ++
 rtl/vga_axis_cnt.sv | 44 ++++
 rtl/vga_timing_gen.sv | 97 +++++++++
 tb/tb_vga_timing_gen.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing defaults and the 3-bit {R,G,B} colour codes
// used by both the timing generator and the pattern generators.
package vga_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;
  localparam logic SYNC_POL_D = 1'b0;

  typedef enum logic [2:0] {
    BLACK  = 3'b000,
    BLUE   = 3'b001,
    GREEN  = 3'b010,
    CYAN   = 3'b011,
    RED    = 3'b100,
    PURPLE = 3'b101,
    YELLOW = 3'b110,
    WHITE  = 3'b111
  } colour_e;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle between the timing generator, the pattern generators and the VGA pins.
interface vga_timing_gen_if;
  logic       pix_en_i;
  logic [2:0] rgb_i;
  logic [8:0] row_o;
  logic [9:0] colum_o;
  logic       hsync_o;
  logic       vsync_o;
  logic       de_o;
  logic [2:0] rgb_o;
  logic       frame_start_o;

  modport master (
    input  pix_en_i, rgb_i,
    output row_o, colum_o, hsync_o, vsync_o, de_o, rgb_o, frame_start_o
  );

  modport slave (
    output pix_en_i, rgb_i,
    input  row_o, colum_o, hsync_o, vsync_o, de_o, rgb_o, frame_start_o
  );
endinterface

// File: rtl/vga_axis_cnt.sv
// One VGA axis: position counter 0..TOTAL-1 with wrap, active-region and sync-window flags.
module vga_axis_cnt #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       carry_i,
  output logic [9:0] cnt_o,
  output logic       wrap_o,
  output logic       active_o,
  output logic       sync_o
);

  // 11-bit bounds so an end point of exactly 1024 still compares correctly
  localparam logic [10:0] LAST_W   = 11'(ACTIVE + FP + SYNC + BP - 1);
  localparam logic [10:0] ACTIVE_W = 11'(ACTIVE);
  localparam logic [10:0] SYNC_LO  = 11'(ACTIVE + FP);
  localparam logic [10:0] SYNC_HI  = 11'(ACTIVE + FP + SYNC);

  logic [9:0]  cnt_r;
  logic [10:0] cnt_x_s;

  assign cnt_x_s  = {1'b0, cnt_r};
  assign wrap_o   = carry_i && (cnt_x_s == LAST_W);
  assign active_o = (cnt_x_s < ACTIVE_W);
  assign sync_o   = (cnt_x_s >= SYNC_LO) && (cnt_x_s < SYNC_HI);
  assign cnt_o    = cnt_r;

  // Position counter: steps on enabled carry, returns to zero after the last position
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= 10'd0;
    end else if (en_i && carry_i) begin
      cnt_r <= wrap_o ? 10'd0 : (cnt_r + 10'd1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: drives row/column to the pattern generators and registers their RGB
// one pixel later together with hsync, vsync, data-enable and a frame-start pulse.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_D,
  parameter int   H_FP     = H_FP_D,
  parameter int   H_SYNC   = H_SYNC_D,
  parameter int   H_BP     = H_BP_D,
  parameter int   V_ACTIVE = V_ACTIVE_D,
  parameter int   V_FP     = V_FP_D,
  parameter int   V_SYNC   = V_SYNC_D,
  parameter int   V_BP     = V_BP_D,
  parameter logic SYNC_POL = SYNC_POL_D
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if ((H_TOTAL > 1024) || (V_TOTAL > 1024) || (V_ACTIVE > 512)) begin : g_bad_geometry
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024 and V_ACTIVE <= 512");
    end
  endgenerate

  logic [9:0] h_cnt_s;
  logic [9:0] v_cnt_s;
  logic       h_wrap_s, v_wrap_s;
  logic       h_act_s, v_act_s;
  logic       h_sync_s, v_sync_s;
  logic       de_s;

  logic       de_r;
  logic [2:0] rgb_r;
  logic       hsync_r;
  logic       vsync_r;
  logic       frame_start_r;
  logic       at_origin_r;

  vga_axis_cnt #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (vga.pix_en_i),
    .carry_i  (1'b1),
    .cnt_o    (h_cnt_s),
    .wrap_o   (h_wrap_s),
    .active_o (h_act_s),
    .sync_o   (h_sync_s)
  );

  vga_axis_cnt #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (vga.pix_en_i),
    .carry_i  (h_wrap_s),
    .cnt_o    (v_cnt_s),
    .wrap_o   (v_wrap_s),
    .active_o (v_act_s),
    .sync_o   (v_sync_s)
  );

  assign de_s        = h_act_s && v_act_s;
  assign vga.row_o   = v_act_s ? 9'(v_cnt_s) : 9'd0;
  assign vga.colum_o = h_act_s ? h_cnt_s : 10'd0;

  // Output stage: one pixel behind the counters; at_origin_r marks counters sitting at (0,0)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      de_r          <= 1'b0;
      rgb_r         <= BLACK;
      hsync_r       <= ~SYNC_POL;
      vsync_r       <= ~SYNC_POL;
      frame_start_r <= 1'b0;
      at_origin_r   <= 1'b1;
    end else if (vga.pix_en_i) begin
      de_r          <= de_s;
      rgb_r         <= de_s ? vga.rgb_i : BLACK;
      hsync_r       <= h_sync_s ? SYNC_POL : ~SYNC_POL;
      vsync_r       <= v_sync_s ? SYNC_POL : ~SYNC_POL;
      frame_start_r <= at_origin_r;
      at_origin_r   <= v_wrap_s;
    end else begin
      frame_start_r <= 1'b0;
    end
  end

  assign vga.de_o          = de_r;
  assign vga.rgb_o         = rgb_r;
  assign vga.hsync_o       = hsync_r;
  assign vga.vsync_o       = vsync_r;
  assign vga.frame_start_o = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-geometry instance checked by a queue scoreboard, plus a
// default 640x480 instance checked against hand-computed sync/enable timing.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam logic SP = 1'b0;
  // Small geometry: H 8/2/3/2 (total 15, sync 10..12), V 4/1/2/1 (total 8, sync 5..6)
  localparam int SH_ACT = 8, SH_TOT = 15, SH_SLO = 10, SH_SHI = 13;
  localparam int SV_ACT = 4, SV_TOT = 8,  SV_SLO = 5,  SV_SHI = 7;

  typedef struct packed {
    logic       de;
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
    logic       fs;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b0;
  int   hm = 0;
  int   vm = 0;
  obs_t exp_cur;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  vga_timing_gen_if sif ();
  vga_timing_gen_if dif ();

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(SP)
  ) u_small (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .vga    (sif.master)
  );

  vga_timing_gen u_dflt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .vga    (dif.master)
  );

  function automatic logic [2:0] pat(input logic [8:0] r, input logic [9:0] c);
    pat = c[2:0] ^ {r[1:0], 1'b0} ^ 3'b101;
  endfunction

  assign sif.rgb_i    = pat(sif.row_o, sif.colum_o);
  assign dif.pix_en_i = 1'b1;
  assign dif.rgb_i    = WHITE;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic reset_model();
    hm = 0;
    vm = 0;
    exp_cur = '{de: 1'b0, rgb: 3'b000, hs: ~SP, vs: ~SP, fs: 1'b0};
  endtask

  // Called at a negedge: drive pix_en, check row/colum, queue the response after the next posedge
  task automatic step(input logic en);
    sif.pix_en_i = en;
    chk("row", int'(sif.row_o), (vm < SV_ACT) ? vm : 0);
    chk("colum", int'(sif.colum_o), (hm < SH_ACT) ? hm : 0);
    if (en) begin
      exp_cur.de  = (hm < SH_ACT) && (vm < SV_ACT);
      exp_cur.rgb = exp_cur.de ? pat(9'(vm), 10'(hm)) : 3'b000;
      exp_cur.hs  = (hm >= SH_SLO && hm < SH_SHI) ? SP : ~SP;
      exp_cur.vs  = (vm >= SV_SLO && vm < SV_SHI) ? SP : ~SP;
      exp_cur.fs  = (hm == 0) && (vm == 0);
      hm++;
      if (hm == SH_TOT) begin
        hm = 0;
        vm++;
        if (vm == SV_TOT) vm = 0;
      end
    end else begin
      exp_cur.fs = 1'b0;
    end
    exp_q.push_back(exp_cur);
    @(negedge clk);
  endtask

  // Scoreboard monitor: pops one expected response per clock while enabled
  initial begin
    obs_t a;
    obs_t e;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        a = {sif.de_o, sif.rgb_o, sif.hsync_o, sif.vsync_o, sif.frame_start_o};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_underflow t=%0t actual=%b expected=<none>", $time, a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            failures++;
            $display("FAIL sb_out t=%0t actual(de,rgb,hs,vs,fs)=%b expected=%b", $time, a, e);
          end
        end
      end
    end
  end

  task automatic small_run();
    mon_en = 1'b1;
    repeat (2 * SH_TOT * SV_TOT) step(1'b1);
    for (int i = 0; i < 2 * SH_TOT * SV_TOT; i++) step((i % 2) == 0);
    mon_en = 1'b0;
  endtask

  // Default-geometry timing, counted in clocks after reset release with pix_en tied high
  task automatic dflt_run();
    int   fall1 = -1, rise1 = -1, fall2 = -1;
    int   de_line = 0, rgb_bad = 0, vs_low = 0, fs_cnt = 0, fs_k = -1;
    logic prev_hs = 1'b1;
    for (int k = 1; k <= 1700; k++) begin
      @(posedge clk);
      #2;
      if (prev_hs && !dif.hsync_o) begin
        if (fall1 < 0) fall1 = k;
        else if (fall2 < 0) fall2 = k;
      end
      if (!prev_hs && dif.hsync_o && rise1 < 0) rise1 = k;
      prev_hs = dif.hsync_o;
      if (k <= 800 && dif.de_o) de_line++;
      if (dif.rgb_o !== (dif.de_o ? 3'b111 : 3'b000)) rgb_bad++;
      if (!dif.vsync_o) vs_low++;
      if (dif.frame_start_o) begin
        fs_cnt++;
        if (fs_k < 0) fs_k = k;
      end
    end
    chk("dflt_hsync_first_fall", fall1, 657);
    chk("dflt_hsync_width_end", rise1, 753);
    chk("dflt_hsync_period", fall2 - fall1, 800);
    chk("dflt_de_per_line", de_line, 640);
    chk("dflt_rgb_vs_de", rgb_bad, 0);
    chk("dflt_vsync_low_early", vs_low, 0);
    chk("dflt_fs_count", fs_cnt, 1);
    chk("dflt_fs_clk", fs_k, 1);
  endtask

  initial begin
    sif.pix_en_i = 1'b0;
    reset_model();
    repeat (3) @(negedge clk);
    chk("rst_small_de", int'(sif.de_o), 0);
    chk("rst_small_rgb", int'(sif.rgb_o), 0);
    chk("rst_small_hs", int'(sif.hsync_o), 1);
    chk("rst_small_vs", int'(sif.vsync_o), 1);
    chk("rst_small_fs", int'(sif.frame_start_o), 0);
    chk("rst_dflt_hs", int'(dif.hsync_o), 1);
    chk("rst_dflt_vs", int'(dif.vsync_o), 1);
    rst_n = 1'b1;
    fork
      small_run();
      dflt_run();
    join

    // Walk into the active area to (h=5, v=2), then reset asynchronously mid-frame
    @(negedge clk);
    mon_en = 1'b1;
    repeat (2 * SH_TOT + 5) step(1'b1);
    mon_en = 1'b0;
    chk("pre_rst_de", int'(sif.de_o), 1);
    chk("pre_rst_rgb", int'(sif.rgb_o), int'(pat(9'd2, 10'd4)));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_de", int'(sif.de_o), 0);
    chk("async_rst_rgb", int'(sif.rgb_o), 0);
    chk("async_rst_hs", int'(sif.hsync_o), 1);
    chk("async_rst_vs", int'(sif.vsync_o), 1);
    chk("async_rst_fs", int'(sif.frame_start_o), 0);
    chk("async_rst_row", int'(sif.row_o), 0);
    chk("async_rst_colum", int'(sif.colum_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    mon_en = 1'b1;
    repeat (20) step(1'b1);
    step(1'b0);
    step(1'b1);
    mon_en = 1'b0;
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
